// File: rtl/lc3_mem_ctrl_pkg.sv
// rtl/lc3_mem_ctrl_pkg.sv - shared types and constants for the LC-3 memory controller (lc3Pkg)
package lc3Pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } MemStates;

  localparam logic [15:0] IO_BASE   = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  localparam logic [7:0] KB_INT_VECTOR   = 8'h80;
  localparam logic [2:0] KB_INT_PRIORITY = 3'd4;

  // Everything from xFE00 upward belongs to the device page, not RAM.
  function automatic logic is_io(input logic [15:0] a);
    return a >= IO_BASE;
  endfunction

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// rtl/lc3_mem_ctrl_if.sv - core <-> memory handshake and interrupt request bundle
interface lc3_mem_ctrl_if;
  logic        memEN;
  logic        memWE;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData;
  logic        memRDY;
  logic        INT;
  logic [7:0]  intVector;
  logic [2:0]  intPriority;

  modport master (
    output memEN, memWE, memAddr, memWData,
    input  memRData, memRDY, INT, intVector, intPriority
  );

  modport slave (
    input  memEN, memWE, memAddr, memWData,
    output memRData, memRDY, INT, intVector, intPriority
  );
endinterface

// File: rtl/lc3_mem_ctrl_mmio.sv
// rtl/lc3_mem_ctrl_mmio.sv - keyboard, display and machine-control registers plus keyboard interrupt
module lc3_mmio
  import lc3Pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_acc,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_rd_addr,
  output logic [15:0] o_rdata,
  input  logic        i_kb_valid,
  input  logic [7:0]  i_kb_data,
  output logic        o_kb_ready,
  output logic        o_disp_valid,
  output logic [7:0]  o_disp_data,
  input  logic        i_disp_ack,
  output logic        o_halt,
  output logic        o_int
);

  logic       r_kb_full;
  logic       r_kb_ie;
  logic [7:0] r_kbdr;
  logic       r_disp_valid;
  logic [7:0] r_disp_data;
  logic       r_mcr_ce;
  logic       r_halt;
  logic       r_int;
  logic       w_rd;
  logic       w_wr;
  logic       w_unused_wdata;

  // i_acc is the READY cycle, so side effects land at its end.
  assign w_rd           = i_acc & ~i_we;
  assign w_wr           = i_acc & i_we;
  assign w_unused_wdata = ^i_wdata[13:8];

  // Keyboard: capture when ready; a completed KBDR read frees the slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_kb_full <= 1'b0;
      r_kb_ie   <= 1'b0;
      r_kbdr    <= 8'h00;
    end else begin
      if (i_kb_valid && !r_kb_full) begin
        r_kbdr    <= i_kb_data;
        r_kb_full <= 1'b1;
      end
      if (w_rd && i_addr == KBDR_ADDR) r_kb_full <= 1'b0;
      if (w_wr && i_addr == KBSR_ADDR) r_kb_ie <= i_wdata[14];
    end
  end

  // Display: ack drops the pending character; DDR writes only land when empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_disp_valid <= 1'b0;
      r_disp_data  <= 8'h00;
    end else begin
      if (i_disp_ack) r_disp_valid <= 1'b0;
      if (w_wr && i_addr == DDR_ADDR && !r_disp_valid) begin
        r_disp_data  <= i_wdata[7:0];
        r_disp_valid <= 1'b1;
      end
    end
  end

  // Machine control: clearing the clock-enable bit latches halt until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcr_ce <= 1'b1;
      r_halt   <= 1'b0;
    end else if (w_wr && i_addr == MCR_ADDR) begin
      r_mcr_ce <= i_wdata[15];
      if (!i_wdata[15]) r_halt <= 1'b1;
    end
  end

  // Registered keyboard interrupt request.
  always_ff @(posedge clk) begin
    if (!rst) r_int <= 1'b0;
    else      r_int <= r_kb_full & r_kb_ie;
  end

  // Device read mux; unmapped device addresses read as zero.
  always_comb begin
    o_rdata = 16'h0000;
    case (i_rd_addr)
      KBSR_ADDR: o_rdata = {r_kb_full, r_kb_ie, 14'h0000};
      KBDR_ADDR: o_rdata = {8'h00, r_kbdr};
      DSR_ADDR:  o_rdata = {~r_disp_valid, 15'h0000};
      MCR_ADDR:  o_rdata = {r_mcr_ce, 15'h0000};
      default:   o_rdata = 16'h0000;
    endcase
  end

  assign o_kb_ready   = ~r_kb_full;
  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = r_disp_data;
  assign o_halt       = r_halt;
  assign o_int        = r_int;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 memory responder with wait states; devices enabled by LC3_MMIO_EN
module lc3_mem_ctrl
  import lc3Pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             rst,
  lc3_mem_ctrl_if.slave    bus,
  input  logic             kbValid,
  input  logic [7:0]       kbData,
  output logic             kbReady,
  output logic             dispValid,
  output logic [7:0]       dispData,
  input  logic             dispAck,
  output logic             halt
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  MemStates    r_state;
  MemStates    w_next;
  logic [15:0] r_addr;
  logic [15:0] r_rdata;
  logic [3:0]  r_cnt;
  logic [15:0] r_ram [DEPTH];

  logic        w_capture;
  logic        w_ready;
  logic        w_load_rdata;
  logic        w_ram_we;
  logic        w_rd_io;
  logic        w_wr_io;
  logic        w_int;
  logic [15:0] w_rd_addr;
  logic [15:0] w_ram_q;
  logic [15:0] w_io_rdata;
  logic [15:0] w_rd_data;
  logic        w_unused_addr;

  // Next-state: one access at a time, WAIT skipped entirely when no wait states.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.memEN) begin
          w_capture = 1'b1;
          w_next    = (WAIT_STATES == 0) ? READY : WAIT;
        end
      end
      WAIT:    if (r_cnt <= 4'd1) w_next = READY;
      READY:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The read address is the live bus address when going straight from IDLE to READY.
  assign w_ready      = (r_state == READY);
  assign w_load_rdata = (w_next == READY) && !w_ready;
  assign w_rd_addr    = (r_state == IDLE) ? bus.memAddr : r_addr;
  assign w_ram_q      = r_ram[w_rd_addr[ADDR_W-1:0]];
  assign w_rd_data    = w_rd_io ? w_io_rdata : w_ram_q;
  assign w_ram_we     = rst && w_ready && bus.memWE && !w_wr_io;
  assign w_unused_addr = ^{r_addr, w_rd_addr};

  // State register, address/counter capture and read-data register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= 16'h0000;
      r_cnt   <= 4'd0;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_addr <= bus.memAddr;
        r_cnt  <= WS_LOAD;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_load_rdata) r_rdata <= w_rd_data;
    end
  end

  // RAM write commits at the end of READY; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[r_addr[ADDR_W-1:0]] <= bus.memWData;
  end

`ifdef LC3_MMIO_EN
  assign w_rd_io = is_io(w_rd_addr);
  assign w_wr_io = is_io(r_addr);

  lc3_mmio u_mmio (
    .clk          (clk),
    .rst          (rst),
    .i_acc        (w_ready),
    .i_we         (bus.memWE),
    .i_addr       (r_addr),
    .i_wdata      (bus.memWData),
    .i_rd_addr    (w_rd_addr),
    .o_rdata      (w_io_rdata),
    .i_kb_valid   (kbValid),
    .i_kb_data    (kbData),
    .o_kb_ready   (kbReady),
    .o_disp_valid (dispValid),
    .o_disp_data  (dispData),
    .i_disp_ack   (dispAck),
    .o_halt       (halt),
    .o_int        (w_int)
  );
`else
  logic w_unused_dev;
  assign w_rd_io      = 1'b0;
  assign w_wr_io      = 1'b0;
  assign w_io_rdata   = 16'h0000;
  assign kbReady      = 1'b0;
  assign dispValid    = 1'b0;
  assign dispData     = 8'h00;
  assign halt         = 1'b0;
  assign w_int        = 1'b0;
  assign w_unused_dev = ^{kbValid, kbData, dispAck};
`endif

  assign bus.memRDY      = w_ready;
  assign bus.memRData    = r_rdata;
  assign bus.INT         = w_int;
  assign bus.intVector   = KB_INT_VECTOR;
  assign bus.intPriority = KB_INT_PRIORITY;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb/tb_lc3_mem_ctrl.sv - directed self-checking bench for lc3_mem_ctrl
module tb_lc3_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       kbValid;
  logic [7:0] kbData;
  logic       kbReady;
  logic       dispValid;
  logic [7:0] dispData;
  logic       dispAck;
  logic       halt;

  int n_tests = 0;
  int n_fail  = 0;

  lc3_mem_ctrl_if bus();

  lc3_mem_ctrl #(.ADDR_W(12), .WAIT_STATES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .kbValid   (kbValid),
    .kbData    (kbData),
    .kbReady   (kbReady),
    .dispValid (dispValid),
    .dispData  (dispData),
    .dispAck   (dispAck),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge with the controller idle; returns #1 after READY ends.
  task automatic access(input logic [15:0] a, input logic we, input logic [15:0] wd,
                        output logic [15:0] rd, output int lat);
    rd = 16'h0000;
    lat = 0;
    bus.memEN   = 1'b1;
    bus.memAddr = a;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 lat++;
      if (bus.memRDY) break;
    end
    bus.memEN = 1'b0;
    if (!bus.memRDY) begin
      check("rdy_timeout", 16'd0, 16'd1);
      lat = -1;
    end else begin
      rd = bus.memRData;
      bus.memWE    = we;
      bus.memWData = wd;
      @(posedge clk);
      #1 bus.memWE = 1'b0;
    end
  endtask

  logic [15:0] rd;
  int          lat;
  int          first_rdy;
  int          second_rdy;
  logic        seen;

  initial begin
    rst = 1'b0;
    bus.memEN = 1'b0;
    bus.memWE = 1'b0;
    bus.memAddr = 16'h0000;
    bus.memWData = 16'h0000;
    kbValid = 1'b0;
    kbData = 8'h00;
    dispAck = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    check("rst_rdy", {15'd0, bus.memRDY}, 16'd0);
    check("rst_rdata", bus.memRData, 16'h0000);
    check("rst_int", {15'd0, bus.INT}, 16'd0);
    check("rst_disp_valid", {15'd0, dispValid}, 16'd0);
    check("rst_disp_data", {8'd0, dispData}, 16'h0000);
    check("rst_halt", {15'd0, halt}, 16'd0);
    check("int_vector", {8'd0, bus.intVector}, 16'h0080);
    check("int_priority", {13'd0, bus.intPriority}, 16'd4);
`ifdef LC3_MMIO_EN
    check("rst_kb_ready", {15'd0, kbReady}, 16'd1);
`else
    check("rst_kb_ready", {15'd0, kbReady}, 16'd0);
`endif

    access(16'h3000, 1'b1, 16'h1234, rd, lat);
    check("wr_latency", 16'(lat), 16'd3);
    access(16'h3000, 1'b0, 16'h0000, rd, lat);
    check("rd_latency", 16'(lat), 16'd3);
    check("rd_3000", rd, 16'h1234);

    access(16'h4000, 1'b1, 16'hBEEF, rd, lat);
    access(16'h3000, 1'b0, 16'h0000, rd, lat);
    check("alias_3000", rd, 16'hBEEF);

    bus.memEN = 1'b1;
    bus.memAddr = 16'h3000;
    first_rdy = -1;
    second_rdy = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.memRDY) begin
        if (first_rdy < 0) first_rdy = i;
        else begin
          second_rdy = i;
          rd = bus.memRData;
          bus.memEN = 1'b0;
          break;
        end
      end
    end
    bus.memEN = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_first", 16'(first_rdy), 16'd3);
    check("b2b_period", 16'(second_rdy - first_rdy), 16'd4);
    check("b2b_data", rd, 16'hBEEF);

    access(16'h3010, 1'b1, 16'h5555, rd, lat);
    bus.memEN = 1'b1;
    bus.memWE = 1'b1;
    bus.memWData = 16'h7777;
    bus.memAddr = 16'h3010;
    @(posedge clk);
    #1 bus.memEN = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 if (bus.memRDY) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1 if (bus.memRDY) seen = 1'b1;
    end
    bus.memWE = 1'b0;
    check("abort_no_rdy", {15'd0, seen}, 16'd0);
    access(16'h3010, 1'b0, 16'h0000, rd, lat);
    check("abort_old_data", rd, 16'h5555);

`ifdef LC3_MMIO_EN
    kbData = 8'h41;
    kbValid = 1'b1;
    @(posedge clk);
    #1 kbValid = 1'b0;
    check("kb_ready_full", {15'd0, kbReady}, 16'd0);
    check("int_no_ie", {15'd0, bus.INT}, 16'd0);
    access(16'hFE00, 1'b1, 16'h4000, rd, lat);
    @(posedge clk);
    #1;
    check("int_set", {15'd0, bus.INT}, 16'd1);
    access(16'hFE00, 1'b0, 16'h0000, rd, lat);
    check("kbsr_full", rd, 16'hC000);
    access(16'hFE02, 1'b0, 16'h0000, rd, lat);
    check("kbdr_read", rd, 16'h0041);
    check("kb_ready_free", {15'd0, kbReady}, 16'd1);
    @(posedge clk);
    #1;
    check("int_clear", {15'd0, bus.INT}, 16'd0);
    access(16'hFE00, 1'b0, 16'h0000, rd, lat);
    check("kbsr_empty", rd, 16'h4000);

    access(16'hFE06, 1'b1, 16'h0048, rd, lat);
    check("disp_valid", {15'd0, dispValid}, 16'd1);
    check("disp_data", {8'd0, dispData}, 16'h0048);
    access(16'hFE04, 1'b0, 16'h0000, rd, lat);
    check("dsr_busy", rd, 16'h0000);
    access(16'hFE06, 1'b1, 16'h0055, rd, lat);
    check("ddr_dropped", {8'd0, dispData}, 16'h0048);
    dispAck = 1'b1;
    @(posedge clk);
    #1 dispAck = 1'b0;
    check("disp_acked", {15'd0, dispValid}, 16'd0);
    access(16'hFE04, 1'b0, 16'h0000, rd, lat);
    check("dsr_ready", rd, 16'h8000);
    access(16'hFE06, 1'b0, 16'h0000, rd, lat);
    check("ddr_read_zero", rd, 16'h0000);

    access(16'hFE10, 1'b1, 16'hFFFF, rd, lat);
    access(16'hFE10, 1'b0, 16'h0000, rd, lat);
    check("unmapped_io", rd, 16'h0000);

    access(16'hFFFE, 1'b0, 16'h0000, rd, lat);
    check("mcr_reset", rd, 16'h8000);
    access(16'hFFFE, 1'b1, 16'h0000, rd, lat);
    check("halt_set", {15'd0, halt}, 16'd1);
    access(16'hFFFE, 1'b0, 16'h0000, rd, lat);
    check("mcr_cleared", rd, 16'h0000);
    access(16'hFFFE, 1'b1, 16'h8000, rd, lat);
    check("halt_sticky", {15'd0, halt}, 16'd1);
    do_reset();
    check("halt_reset", {15'd0, halt}, 16'd0);
`else
    access(16'hFFFE, 1'b1, 16'hABCD, rd, lat);
    access(16'hFFFE, 1'b0, 16'h0000, rd, lat);
    check("mcr_as_ram", rd, 16'hABCD);
    access(16'h0FFE, 1'b0, 16'h0000, rd, lat);
    check("mcr_alias", rd, 16'hABCD);
    access(16'hFFFE, 1'b1, 16'h0000, rd, lat);
    check("no_halt", {15'd0, halt}, 16'd0);
    access(16'hFFFE, 1'b0, 16'h0000, rd, lat);
    check("mcr_zero_stored", rd, 16'h0000);
    kbValid = 1'b1;
    kbData = 8'h41;
    @(posedge clk);
    #1 kbValid = 1'b0;
    check("no_kb_ready", {15'd0, kbReady}, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
